// File: rtl/inst_mem_loader_pkg.sv
// rtl/inst_mem_loader_pkg.sv - shared state encoding and byte-enable constants for the loader
package inst_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } load_state_t;

  // Same encoding as the data-memory per-byte write enables
  localparam logic [3:0] WE_WORD = 4'b1111;
  localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/inst_mem_loader_byte_word_assembler.sv
// rtl/inst_mem_loader_byte_word_assembler.sv - LSB-first byte-to-word shift register
module byte_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [1:0] byte_cnt;

  // New bytes enter at the top so the first byte ends up in bits [7:0]
  assign word_next = {byte_in, word[31:8]};
  // Flags the handshake that completes a word; word_next is the full word then
  assign word_full = shift && (byte_cnt == 2'd3);

  // Byte counter and shift register; the 2-bit counter wraps between words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      word     <= 32'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      word     <= 32'd0;
    end else if (shift) begin
      byte_cnt <= byte_cnt + 2'd1;
      word     <= word_next;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - boot-time instruction-memory loader with pipeline hold
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST,
  input  logic              load_start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic [3:0]        imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum
);

  // A length of exactly 2^ADDR_W words fills memory; anything larger is rejected
  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

  load_state_t       state, state_next;
  logic              handshake;
  logic              asm_clear;
  logic [31:0]       asm_word;
  logic [31:0]       asm_word_next;
  logic              word_full;
  logic              len_overflow;
  logic [31:0]       count;
  logic [ADDR_W:0]   index;
  logic [ADDR_W:0]   index_inc;

  assign handshake    = rx_valid && rx_ready;
  assign asm_clear    = (state == ST_IDLE) || (state == ST_DONE);
  assign len_overflow = {1'b0, asm_word_next} > CAPACITY;
  assign index_inc    = index + 1'b1;

  byte_word_assembler u_asm (
    .clk       (CPU_CLK),
    .rst       (CPU_RST),
    .clear     (asm_clear),
    .shift     (handshake),
    .byte_in   (rx_data),
    .word      (asm_word),
    .word_next (asm_word_next),
    .word_full (word_full)
  );

  // State register
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (load_start) state_next = ST_LEN;
      ST_LEN: begin
        if (word_full) begin
          if (asm_word_next == 32'd0 || len_overflow) state_next = ST_DONE;
          else                                        state_next = ST_DATA;
        end
      end
      ST_DATA:  if (word_full) state_next = ST_WRITE;
      ST_WRITE: state_next = (32'(index_inc) == count) ? ST_DONE : ST_DATA;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register only; address/data are zero outside WRITE
  always_comb begin
    rx_ready   = 1'b0;
    cpu_hold   = 1'b0;
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    imem_we    = WE_NONE;
    imem_addr  = '0;
    imem_wdata = 32'd0;
    case (state)
      ST_LEN:  begin rx_ready = 1'b1; cpu_hold = 1'b1; end
      ST_DATA: begin rx_ready = 1'b1; cpu_hold = 1'b1; end
      ST_WRITE: begin
        cpu_hold   = 1'b1;
        imem_we    = WE_WORD;
        imem_addr  = index[ADDR_W-1:0];
        imem_wdata = asm_word;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Length, word index, sticky error and running checksum
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      count    <= 32'd0;
      index    <= '0;
      err      <= 1'b0;
      checksum <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            count    <= 32'd0;
            index    <= '0;
            err      <= 1'b0;
            checksum <= 32'd0;
          end
        end
        ST_LEN: begin
          if (word_full) begin
            count <= asm_word_next;
            if (len_overflow) err <= 1'b1;
          end
        end
        ST_WRITE: begin
          checksum <= checksum + asm_word;
          index    <= index_inc;
        end
        default: ;
      endcase
    end
  end

endmodule
